fetch_unit: RTL and testbench

- Instruction fetch stage inside proc; sits between the instruction memory port and decode.
- Owns the PC and issues word fetches using the instr_req/instr_valid handshake.
- Buffers returned words, each with its PC, in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) from execute by flushing the FIFO and discarding any in-flight fetch.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: machine word, instruction,
// fetch FSM states and the buffered {instruction, pc} entry.
package fetch_unit_pkg;

    typedef logic [31:0] word;
    typedef logic [31:0] instr_t;

    localparam word PC_INIT_ADDR = 32'h0000_1000;

    typedef enum logic {
        RELEASE = 1'b0,
        REQ     = 1'b1
    } fetch_state_e;

    typedef struct packed {
        instr_t instr;
        word    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory-side request/response channel and decode-side valid/ready channel
// of the fetch stage; master is the fetch unit, slave is memory plus decode.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic   instr_req;
    word    instr_addr;
    logic   instr_valid;
    instr_t instr_read;

    logic   out_valid;
    logic   out_ready;
    instr_t out_instr;
    word    out_pc;

    modport master (
        output instr_req, instr_addr,
        input  instr_valid, instr_read,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_valid, instr_read,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// DEPTH-entry instruction buffer; push and pop may coincide even when full,
// and flush empties it in one cycle, overriding any push or pop.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         res,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; the empty mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a one-word-at-a-time request
// handshake to memory and queues returned words for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int  DEPTH     = 2,
    parameter word INIT_ADDR = PC_INIT_ADDR
) (
    input  logic         clk,
    input  logic         res,
    input  logic         redirect,
    input  word          redirect_addr,
    fetch_unit_if.master bus
);
    fetch_state_e state_reg, state_next;
    word          pc_reg, pc_next;
    logic         push, pop, full, empty;
    fetch_entry_t wdata, head;

    assign pop   = bus.out_ready && !empty;
    assign wdata = '{instr: bus.instr_read, pc: pc_reg};

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        if (redirect) begin
            // Any response in this cycle belongs to the old stream and is dropped.
            state_next = RELEASE;
            pc_next    = redirect_addr & ~32'd3;
        end else begin
            unique case (state_reg)
                RELEASE: if (!full || pop) state_next = REQ;
                REQ: begin
                    if (bus.instr_valid) begin
                        push       = 1'b1;
                        pc_next    = pc_reg + 32'd4;
                        state_next = RELEASE;
                    end
                end
                default: state_next = RELEASE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= RELEASE;
            pc_reg    <= INIT_ADDR;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.instr_req  = (state_reg == REQ);
    assign bus.instr_addr = pc_reg;
    assign bus.out_valid  = !empty;
    assign bus.out_instr  = head.instr;
    assign bus.out_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory responder, a queue
// model of the expected decode stream, and directed plus random phases.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int  DEPTH = 2;
    localparam word INIT  = 32'h0000_1000;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic redirect = 1'b0;
    word  redirect_addr = '0;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(DEPTH), .INIT_ADDR(INIT)) dut (
        .clk           (clk),
        .res           (res),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic word mem_word(word a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory responder ----------------
    int   lat = 1;
    bit   rand_lat = 1'b0;
    int   mem_cnt = 0;
    int   cur_lat = 1;
    bit   mem_wait_low = 1'b0;

    logic   s_req = 1'b0;
    word    s_addr = '0;
    logic   s_valid = 1'b0;
    word    s_pc = '0;
    instr_t s_instr = '0;

    always @(posedge clk) begin
        #2;
        if (!res) begin
            bus.instr_valid = 1'b0;
            bus.instr_read  = '0;
            mem_cnt         = 0;
            mem_wait_low    = 1'b0;
        end else if (bus.instr_valid) begin
            bus.instr_valid = 1'b0;
            mem_wait_low    = s_req;
            mem_cnt         = 0;
        end else if (mem_wait_low) begin
            if (!s_req) mem_wait_low = 1'b0;
        end else if (s_req) begin
            if (mem_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
            mem_cnt++;
            if (mem_cnt >= cur_lat) begin
                bus.instr_valid = 1'b1;
                bus.instr_read  = mem_word(s_addr);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        word    pc;
        instr_t instr;
    } exp_t;

    exp_t q[$];
    word  m_pc = INIT;
    word  accepted[$];
    word  popped[$];
    bit   hold_pending = 1'b0;
    word  hold_addr = '0;
    bit   must_drop = 1'b0;
    logic prev_req = 1'b0;

    always @(posedge clk) begin
        hold_pending = 1'b0;
        must_drop    = 1'b0;
        if (!res) begin
            q.delete();
            m_pc = INIT;
        end else if (redirect) begin
            q.delete();
            m_pc = redirect_addr & ~32'd3;
            if (s_req) must_drop = 1'b1;
        end else begin
            if (q.size() != 0 && bus.out_ready) begin
                void'(q.pop_front());
                if (s_valid) popped.push_back(s_pc);
            end
            if (s_req && bus.instr_valid) begin
                accepted.push_back(s_addr);
                q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                m_pc      = m_pc + 32'd4;
                must_drop = 1'b1;
            end else if (s_req) begin
                hold_pending = 1'b1;
                hold_addr    = s_addr;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        s_req   = bus.instr_req;
        s_addr  = bus.instr_addr;
        s_valid = bus.out_valid;
        s_pc    = bus.out_pc;
        s_instr = bus.out_instr;
        if (res) begin
            check("out_valid", 32'(s_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_pc", s_pc, q[0].pc);
                check("out_instr", s_instr, q[0].instr);
            end
            if (s_req) check("instr_addr", s_addr, m_pc);
            if (hold_pending) begin
                check("req_held", 32'(s_req), 32'd1);
                check("addr_held", s_addr, hold_addr);
            end
            if (must_drop) check("req_low_after", 32'(s_req), 32'd0);
            if (s_req && !prev_req) check("req_rise_space", 32'(q.size() < DEPTH), 32'd1);
        end
        prev_req = s_req;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        res      = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        accepted.delete();
        popped.delete();
        res = 1'b1;
    endtask

    task automatic wait_accepted(int n, string name);
        for (int i = 0; i < 300 && accepted.size() < n; i++) tick();
        check(name, 32'(accepted.size() >= n), 32'd1);
    endtask

    task automatic wait_popped(int n, string name);
        for (int i = 0; i < 300 && popped.size() < n; i++) tick();
        check(name, 32'(popped.size() >= n), 32'd1);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_req", 32'(bus.instr_req), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_addr", bus.instr_addr, INIT);

        // 1: sequential fetch, latency 1
        lat = 1;
        bus.out_ready = 1'b1;
        res = 1'b1;
        wait_accepted(3, "p1_timeout");
        check("p1_addr0", accepted[0], 32'h1000);
        check("p1_addr1", accepted[1], 32'h1004);
        check("p1_addr2", accepted[2], 32'h1008);
        wait_popped(3, "p1_pop_timeout");
        check("p1_pc0", popped[0], 32'h1000);
        check("p1_pc1", popped[1], 32'h1004);
        check("p1_pc2", popped[2], 32'h1008);

        // 2: decode stalled for 20 cycles
        bus.out_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        check("p2_valid", 32'(bus.out_valid), 32'd1);
        check("p2_head_pc", bus.out_pc, 32'h1000);
        check("p2_head_instr", bus.out_instr, mem_word(32'h1000));
        check("p2_req_idle", 32'(bus.instr_req), 32'd0);
        check("p2_buffered", 32'(accepted.size()), 32'd2);
        bus.out_ready = 1'b1;
        wait_popped(3, "p2_pop_timeout");
        check("p2_pc0", popped[0], 32'h1000);
        check("p2_pc1", popped[1], 32'h1004);
        check("p2_pc2", popped[2], 32'h1008);

        // 3: redirect coinciding with a memory response
        do_reset();
        for (int i = 0; i < 100 && !(bus.instr_valid && bus.instr_req); i++) tick();
        check("p3_found_resp", 32'(bus.instr_valid && bus.instr_req), 32'd1);
        redirect      = 1'b1;
        redirect_addr = 32'h2002;
        tick();
        redirect = 1'b0;
        check("p3_valid_flushed", 32'(bus.out_valid), 32'd0);
        check("p3_req_drop", 32'(bus.instr_req), 32'd0);
        tick();
        check("p3_req_again", 32'(bus.instr_req), 32'd1);
        check("p3_new_addr", bus.instr_addr, 32'h2000);

        // 4: redirect while full with decode ready
        bus.out_ready = 1'b0;
        do_reset();
        wait_accepted(2, "p4_fill_timeout");
        tick();
        check("p4_full_idle", 32'(bus.instr_req), 32'd0);
        bus.out_ready = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 32'h3000;
        popped.delete();
        tick();
        redirect = 1'b0;
        wait_popped(2, "p4_pop_timeout");
        check("p4_first_pc", popped[0], 32'h3000);
        check("p4_second_pc", popped[1], 32'h3004);

        // 5: memory latency 5
        lat = 5;
        do_reset();
        begin
            int n_req = 0;
            for (int i = 0; i < 100; i++) begin
                if (bus.instr_req) n_req++;
                tick();
                if (accepted.size() >= 1) break;
            end
            check("p5_req_cycles", 32'(n_req), 32'd6);
        end
        for (int i = 0; i < 60; i++) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        bus.out_ready = 1'b1;
        check("p5_addr1", accepted[1], 32'h1004);

        // 6: asynchronous reset mid-request
        lat = 3;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 100 && !(accepted.size() >= 1 && bus.instr_req && !bus.instr_valid); i++) tick();
        check("p6_in_req", 32'(bus.instr_req), 32'd1);
        #2;
        res = 1'b0;
        #1;
        check("p6_req_async", 32'(bus.instr_req), 32'd0);
        check("p6_valid_async", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        accepted.delete();
        popped.delete();
        bus.out_ready = 1'b1;
        res = 1'b1;
        wait_accepted(1, "p6_restart_timeout");
        check("p6_restart_addr", accepted[0], INIT);

        // 7: PC wrap, then randomized traffic
        lat = 1;
        do_reset();
        redirect      = 1'b1;
        redirect_addr = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        accepted.delete();
        wait_accepted(2, "p7_wrap_timeout");
        check("p7_wrap0", accepted[0], 32'hFFFF_FFFC);
        check("p7_wrap1", accepted[1], 32'h0000_0000);
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 15) == 0);
            redirect_addr = $urandom;
            tick();
        end
        redirect = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
